dmem_responder: RTL and testbench

Data-memory responder for the pipeline CPU's load/store port: the target end of the CPU's data-memory request interface. It accepts one request per valid/ready handshake, inserts a configurable number of wait states, performs RV32I byte/half/word loads and stores against an internal word array `ram`, and returns data or an error on a valid/ready response channel. It replaces the zero-latency data memory so the pipeline's stall path can be exercised under realistic memory timing.

---
 rtl/dmem_responder.sv | 153 +++++++++++++++
 tb/tb_dmem_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: one request per handshake,
// LATENCY wait states, RV32I B/H/W loads and stores against an internal word array.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rdata;
    logic        r_err;

    // NOTE: the memory array has no reset; only control state is reset, and the
    // declaration initialiser provides the power-up zero contents.
    logic [31:0] r_ram [2**DEPTH_LOG2] = '{default: '0};

    logic                  w_accept;
    logic                  w_access;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_word;
    logic [31:0]           w_shift;
    logic                  w_bad_f3;
    logic                  w_misalign;
    logic                  w_oor;
    logic                  w_err;
    logic [31:0]           w_ld_data;
    logic [3:0]            w_be;
    logic [31:0]           w_wd;

    assign w_accept = req_valid && (r_state == IDLE);
    // The counter runs down to zero, so the access lands LATENCY+1 edges after accept.
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_next = BUSY;
            BUSY:    if (w_access)   w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default:                 w_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'(LATENCY);
        end else if (r_state == BUSY && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
        end
    end

    assign w_idx   = r_addr[DEPTH_LOG2+1:2];
    assign w_word  = r_ram[w_idx];
    assign w_shift = w_word >> {r_addr[1:0], 3'b000};
    assign w_oor   = (r_addr >> (DEPTH_LOG2 + 2)) != 32'd0;

    // NOTE: every always_comb output gets a default first, so no latches are inferred.
    always_comb begin
        w_bad_f3   = 1'b0;
        w_misalign = 1'b0;
        w_ld_data  = 32'd0;
        w_be       = 4'b0000;
        w_wd       = r_wdata;
        if (r_write) w_bad_f3 = !(r_funct3 inside {3'd0, 3'd1, 3'd2});
        else         w_bad_f3 = !(r_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((r_funct3 == 3'd1 || r_funct3 == 3'd5) && r_addr[0])  w_misalign = 1'b1;
        if (r_funct3 == 3'd2 && r_addr[1:0] != 2'b00)              w_misalign = 1'b1;
        case (r_funct3)
            3'd0: w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd4: w_ld_data = {24'd0, w_shift[7:0]};
            3'd1: w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd5: w_ld_data = {16'd0, w_shift[15:0]};
            3'd2: w_ld_data = w_word;
            default: w_ld_data = 32'd0;
        endcase
        case (r_funct3)
            3'd0: begin w_be = 4'b0001 << r_addr[1:0]; w_wd = {4{r_wdata[7:0]}};  end
            3'd1: begin w_be = 4'b0011 << r_addr[1:0]; w_wd = {2{r_wdata[15:0]}}; end
            3'd2: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_err = w_bad_f3 || w_misalign || w_oor;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_err   <= w_err;
            r_rdata <= (r_write || w_err) ? 32'd0 : w_ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_access && r_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_ram[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH_LOG2=8): one task per feature,
// inline comparisons against hand-computed values.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Drives one request, waits for the response and consumes it. lat is the number
    // of edges after the accept edge before resp_valid is seen.
    task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er,
                       output int lat);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        for (int i = 0; i < 20; i++) begin
            acc = req_ready;
            @(posedge clk);
            if (acc) break;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (!acc || lat >= 50) begin
            n_errors++;
            $display("FAIL txn_timeout addr=%h: accepted=%0d lat=%0d, required accept and response", addr, acc, lat);
        end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic er; int lat;
        reset = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0;
        req_wdata = 32'hAAAA5555; req_funct3 = 3'd2; resp_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
            n_checks++;
            if (resp_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_resp_rdata: got %h want 00000000", resp_rdata); end
        end
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_checks++;
        if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_idle_resp_valid: got %b want 0", resp_valid); end
        txn(1'b0, 32'h0, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_no_store: got %h want 00000000", rd); end
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h0, 32'hDEADBEEF, 3'd2, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin n_errors++; $display("FAIL sw_resp: got err=%b rd=%h want err=0 rd=00000000", er, rd); end
        n_checks++;
        if (lat !== 3) begin n_errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
        txn(1'b0, 32'h0, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_data: got err=%b rd=%h want err=0 rd=deadbeef", er, rd); end
        n_checks++;
        if (lat !== 3) begin n_errors++; $display("FAIL lw_latency: got %0d want 3", lat); end
        txn(1'b1, 32'h3FC, 32'h80000001, 3'd2, rd, er, lat);
        txn(1'b0, 32'h3FC, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'h80000001) begin n_errors++; $display("FAIL lw_last_word: got err=%b rd=%h want err=0 rd=80000001", er, rd); end
    endtask

    task automatic test_byte;
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h4, 32'h11223344, 3'd2, rd, er, lat);
        txn(1'b1, 32'h5, 32'h000000FF, 3'd0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0) begin n_errors++; $display("FAIL sb_err: got %b want 0", er); end
        txn(1'b0, 32'h4, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (rd !== 32'h1122FF44) begin n_errors++; $display("FAIL sb_merge: got %h want 1122ff44", rd); end
        txn(1'b0, 32'h5, 32'h0, 3'd0, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL lb_sign: got %h want ffffffff", rd); end
        txn(1'b0, 32'h5, 32'h0, 3'd4, rd, er, lat);
        n_checks++;
        if (rd !== 32'h000000FF) begin n_errors++; $display("FAIL lbu: got %h want 000000ff", rd); end
        txn(1'b0, 32'h7, 32'h0, 3'd0, rd, er, lat);
        n_checks++;
        if (rd !== 32'h00000011) begin n_errors++; $display("FAIL lb_lane3: got %h want 00000011", rd); end
        txn(1'b0, 32'h4, 32'h0, 3'd1, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFFFF44) begin n_errors++; $display("FAIL lh_low: got %h want ffffff44", rd); end
    endtask

    task automatic test_half;
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'hA, 32'h0000FFFF, 3'd1, rd, er, lat);
        txn(1'b0, 32'h8, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFF0000) begin n_errors++; $display("FAIL sh_merge: got %h want ffff0000", rd); end
        txn(1'b0, 32'hA, 32'h0, 3'd1, rd, er, lat);
        n_checks++;
        if (rd !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL lh_sign: got %h want ffffffff", rd); end
        txn(1'b0, 32'hA, 32'h0, 3'd5, rd, er, lat);
        n_checks++;
        if (rd !== 32'h0000FFFF) begin n_errors++; $display("FAIL lhu: got %h want 0000ffff", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 32'h2, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL lw_misalign: got err=%b rd=%h want err=1 rd=00000000", er, rd); end
        txn(1'b1, 32'h5, 32'h0000ABCD, 3'd1, rd, er, lat);
        n_checks++;
        if (er !== 1'b1) begin n_errors++; $display("FAIL sh_misalign: got %b want 1", er); end
        txn(1'b0, 32'h4, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (rd !== 32'h1122FF44) begin n_errors++; $display("FAIL sh_misalign_nowrite: got %h want 1122ff44", rd); end
        txn(1'b0, 32'h400, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL lw_range: got err=%b rd=%h want err=1 rd=00000000", er, rd); end
        txn(1'b0, 32'h0, 32'h0, 3'd3, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL load_f3_3: got err=%b rd=%h want err=1 rd=00000000", er, rd); end
        txn(1'b1, 32'h0, 32'h0, 3'd4, rd, er, lat);
        n_checks++;
        if (er !== 1'b1) begin n_errors++; $display("FAIL store_f3_4: got %b want 1", er); end
        txn(1'b0, 32'h0, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL store_f3_4_nowrite: got err=%b rd=%h want err=0 rd=deadbeef", er, rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er; int lat; int k;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_funct3 = 3'd2; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        // Offer a store while the load is in flight; it must be ignored.
        req_write = 1'b1; req_wdata = 32'h00000055;
        k = 0;
        while (!resp_valid && k < 50) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== 3) begin n_errors++; $display("FAIL bp_latency: got %0d want 3", k); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp_hold%0d: got v=%b rd=%h err=%b rdy=%b want v=1 rd=deadbeef err=0 rdy=0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
        end
        txn(1'b0, 32'h0, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL bp_store_ignored: got %h want deadbeef", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat; int seen;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_wdata = 32'h12345678; req_funct3 = 3'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (resp_valid) seen++;
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL mid_reset_resp: got %0d valid cycles want 0", seen); end
        txn(1'b0, 32'h0, 32'h0, 3'd2, rd, er, lat);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL mid_reset_ram: got %h want deadbeef", rd); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
